// File: rtl/lsu_pkg.sv
// Shared types and codes for the load/store sequencer.
// State enum, funct3 and memory op codes, cause codes, size helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LBU = 3'b001;
  localparam logic [2:0] LD_LH  = 3'b010;
  localparam logic [2:0] LD_LHU = 3'b011;
  localparam logic [2:0] LD_LW  = 3'b100;

  localparam logic [2:0] ST_SB = 3'b000;
  localparam logic [2:0] ST_SH = 3'b001;
  localparam logic [2:0] ST_SW = 3'b010;

  localparam logic [3:0] C_NONE   = 4'd0;
  localparam logic [3:0] C_ILL    = 4'd2;
  localparam logic [3:0] C_LD_MIS = 4'd4;
  localparam logic [3:0] C_LD_FLT = 5;
  localparam logic [3:0] C_ST_MIS = 4'd6;
  localparam logic [3:0] C_ST_FLT = 4'd7;

  function automatic logic [2:0] acc_size(
    input logic [2:0] f3
  );
    logic [2:0] s;
    unique case (f3[1:0])
      2'b00:   s = 3'd1;
      2'b01:   s = 3'd2;
      default: s = 3'd4;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lsu_addr_check.sv
// Combinational request checker: error/cause, op codes, store lanes.
// In: ea, funct3, is_store, wdata. Out: err, cause, lane_wdata, load_ops, store_ops.
module lsu_addr_check
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic [31:0] ea,
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [31:0] wdata,
  output logic        err,
  output logic [3:0]  cause,
  output logic [31:0] lane_wdata,
  output logic [2:0]  load_ops,
  output logic [2:0]  store_ops
);

  localparam logic [32:0] LIMIT = 33'(MEM_BYTES - 1);

  logic [2:0]  size;
  logic [32:0] last;
  logic        ill;
  logic        mis;
  logic        flt;

  always_comb begin
    size = acc_size(funct3);
    // 33-bit sum so a range that runs past 2^32 still faults
    last = {1'b0, ea} + {30'd0, size} - 33'd1;
    if (is_store) begin
      ill = funct3 > F3_W;
    end else begin
      ill = (funct3 == 3'b011) ||
            (funct3 == 3'b110) ||
            (funct3 == 3'b111);
    end
    mis = ((size == 3'd2) && ea[0]) ||
          ((size == 3'd4) && (ea[1:0] != 2'b00));
    flt = ({1'b0, ea} > LIMIT) || (last > LIMIT);
  end

  always_comb begin
    err   = 1'b1;
    cause = C_NONE;
    priority case (1'b1)
      ill:     cause = C_ILL;
      mis:     cause = is_store ? C_ST_MIS : C_LD_MIS;
      flt:     cause = is_store ? C_ST_FLT : C_LD_FLT;
      default: err = 1'b0;
    endcase
  end

  always_comb begin
    load_ops   = LD_LB;
    store_ops  = ST_SB;
    lane_wdata = 32'd0;
    if (is_store) begin
      store_ops = funct3;
      unique case (funct3[1:0])
        2'b00:   lane_wdata = {4{wdata[7:0]}};
        2'b01:   lane_wdata = {2{wdata[15:0]}};
        default: lane_wdata = wdata;
      endcase
    end else begin
      unique case (funct3)
        F3_B:    load_ops = LD_LB;
        F3_H:    load_ops = LD_LH;
        F3_W:    load_ops = LD_LW;
        F3_BU:   load_ops = LD_LBU;
        F3_HU:   load_ops = LD_LHU;
        default: load_ops = LD_LB;
      endcase
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: req handshake -> one memory cycle -> rsp handshake.
// Ports: req_* from execute, mem_* to data memory, rsp_* back to pipeline.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  output logic        mem_cs,
  output logic        mem_load_store,
  output logic [2:0]  mem_load_ops,
  output logic [2:0]  mem_store_ops,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [3:0]  rsp_cause
);

  state_t      state;
  state_t      state_nx;
  logic        accept;
  logic        st_q;
  logic [31:0] ea;
  logic        chk_err;
  logic [3:0]  chk_cause;
  logic [31:0] chk_wdata;
  logic [2:0]  chk_lops;
  logic [2:0]  chk_sops;

  assign ea = req_base + req_offset;

  lsu_addr_check #(
    .MEM_BYTES(MEM_BYTES)
  ) u_chk (
    .ea        (ea),
    .funct3    (req_funct3),
    .is_store  (req_is_store),
    .wdata     (req_wdata),
    .err       (chk_err),
    .cause     (chk_cause),
    .lane_wdata(chk_wdata),
    .load_ops  (chk_lops),
    .store_ops (chk_sops)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    unique case (state)
      S_IDLE:   req_ready = rst_n;
      S_RESP:   req_ready = rst_n & rsp_ready;
      default:  req_ready = 1'b0;
    endcase
    accept = req_valid & req_ready;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = chk_err ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: state_nx = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          if (accept) begin
            state_nx = chk_err ? S_RESP : S_ACCESS;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q          <= 1'b0;
      mem_addr      <= 32'd0;
      mem_wdata     <= 32'd0;
      mem_load_ops  <= 3'd0;
      mem_store_ops <= 3'd0;
      rsp_rdata     <= 32'd0;
      rsp_err       <= 1'b0;
      rsp_cause     <= 4'd0;
    end else begin
      if (accept) begin
        rsp_err   <= chk_err;
        rsp_cause <= chk_cause;
        rsp_rdata <= 32'd0;
        if (!chk_err) begin
          st_q          <= req_is_store;
          mem_addr      <= ea;
          mem_wdata     <= chk_wdata;
          mem_load_ops  <= chk_lops;
          mem_store_ops <= chk_sops;
        end
      end
      if ((state == S_ACCESS) && !st_q) begin
        rsp_rdata <= mem_rdata;
      end
    end
  end

  always_comb begin
    mem_cs         = 1'b1;
    mem_load_store = 1'b1;
    if (state == S_ACCESS) begin
      mem_cs         = 1'b0;
      mem_load_store = ~st_q;
    end
  end

  assign rsp_valid = (state == S_RESP);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl with a byte-array memory and reference model.
// Drives random and directed requests; monitors check mem and rsp sides.
module tb_lsu_ctrl;

  localparam int MB = 1024;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [31:0] req_wdata;
  logic        mem_cs;
  logic        mem_load_store;
  logic [2:0]  mem_load_ops;
  logic [2:0]  mem_store_ops;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [3:0]  rsp_cause;

  lsu_ctrl #(.MEM_BYTES(MB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_is_store  (req_is_store),
    .req_funct3    (req_funct3),
    .req_base      (req_base),
    .req_offset    (req_offset),
    .req_wdata     (req_wdata),
    .mem_cs        (mem_cs),
    .mem_load_store(mem_load_store),
    .mem_load_ops  (mem_load_ops),
    .mem_store_ops (mem_store_ops),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .rsp_cause     (rsp_cause)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  cause;
    int          first;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic        st;
    logic [2:0]  lops;
    logic [2:0]  sops;
    logic [31:0] wdata;
    int          cyc;
  } acc_t;

  rsp_t        rq[$];
  acc_t        aq[$];
  logic [7:0]  ram [MB];
  logic [7:0]  ref_mem [MB];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          rr_mode = 0;
  logic [2:0]  lops_tab [8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rr_mode == 0) rsp_ready = 1'($urandom_range(0, 1));
    else if (rr_mode == 1) rsp_ready = 1'b0;
    else rsp_ready = 1'b1;
  end

  // Data memory: extends loads combinationally, writes on posedge.
  logic [9:0] a0;
  logic [7:0] b0, b1, b2, b3;
  always_comb begin
    a0 = mem_addr[9:0];
    b0 = ram[a0];
    b1 = ram[a0 + 10'd1];
    b2 = ram[a0 + 10'd2];
    b3 = ram[a0 + 10'd3];
    mem_rdata = 32'd0;
    case (mem_load_ops)
      3'b000:  mem_rdata = {{24{b0[7]}}, b0};
      3'b001:  mem_rdata = {24'd0, b0};
      3'b010:  mem_rdata = {{16{b1[7]}}, b1, b0};
      3'b011:  mem_rdata = {16'd0, b1, b0};
      3'b100:  mem_rdata = {b3, b2, b1, b0};
      default: mem_rdata = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (!mem_cs && !mem_load_store) begin
      for (int k = 0; k < 4; k++) begin
        if (k < (mem_store_ops == 3'b000 ? 1 :
                 mem_store_ops == 3'b001 ? 2 : 4)) begin
          ram[a0 + 10'(k)] <= mem_wdata[8*((a0[1:0]+k)%4) +: 8];
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: derive expected access and response from the rules.
  task automatic model(bit st, logic [2:0] f3, logic [31:0] b,
                       logic [31:0] o, logic [31:0] w, int c);
    logic [31:0]     ea;
    int              sz;
    bit              ill, mis, flt;
    longint unsigned eal;
    longint          v;
    rsp_t            rs;
    acc_t            ac;
    ea  = b + o;
    eal = longint'({32'd0, ea});
    sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ill = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    mis = (ea % sz) != 0;
    flt = (eal + longint'(sz) - 1) > (MB - 1);
    rs.err   = ill | mis | flt;
    rs.cause = ill ? 4'd2 : mis ? (st ? 4'd6 : 4'd4) :
               flt ? (st ? 4'd7 : 4'd5) : 4'd0;
    rs.rdata = 32'd0;
    if (rs.err) begin
      rs.first = c + 1;
    end else begin
      rs.first = c + 2;
      ac.addr = ea;
      ac.st   = st;
      ac.lops = lops_tab[f3];
      ac.sops = f3;
      ac.cyc  = c + 1;
      ac.wdata = 32'd0;
      for (int i = 0; i < 4; i++) ac.wdata[8*i +: 8] = w[8*(i%sz) +: 8];
      aq.push_back(ac);
      if (st) begin
        for (int k = 0; k < sz; k++) ref_mem[int'(ea) + k] = w[8*k +: 8];
      end else begin
        v = 0;
        for (int k = 0; k < sz; k++)
          v += longint'(ref_mem[int'(ea) + k]) << (8 * k);
        if (!f3[2] && sz < 4 && v >= (longint'(1) << (8*sz - 1)))
          v -= longint'(1) << (8 * sz);
        rs.rdata = 32'(v);
      end
    end
    rq.push_back(rs);
  endtask

  task automatic issue(bit st, logic [2:0] f3, logic [31:0] b,
                       logic [31:0] o, logic [31:0] w);
    bit ok;
    ok = 0;
    req_is_store = st;
    req_funct3   = f3;
    req_base     = b;
    req_offset   = o;
    req_wdata    = w;
    req_valid    = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (req_ready === 1'b1) ok = 1;
    end
    if (!ok) begin
      chk("req_timeout", 32'(req_ready), 32'd1);
    end else begin
      model(st, f3, b, o, w, cyc);
    end
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_is_store = 1'($urandom_range(0, 1));
    req_funct3   = 3'($urandom_range(0, 7));
    req_base     = $urandom;
    req_offset   = $urandom;
    req_wdata    = $urandom;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && (rq.size() > 0 || aq.size() > 0); n++)
      @(posedge clk);
    chk("drain_rq", 32'(rq.size()), 32'd0);
    chk("drain_aq", 32'(aq.size()), 32'd0);
    #1;
  endtask

  // Memory-side monitor
  initial forever begin
    @(negedge clk);
    if (rst_n && !mem_cs) begin
      chk("acc_req_ready", 32'(req_ready), 32'd0);
      if (aq.size() == 0) begin
        chk("acc_unexpected", 32'(mem_cs), 32'd1);
      end else begin
        chk("acc_cycle", 32'(cyc), 32'(aq[0].cyc));
        chk("acc_addr", mem_addr, aq[0].addr);
        chk("acc_ls", 32'(mem_load_store), 32'(!aq[0].st));
        if (aq[0].st) begin
          chk("acc_sops", 32'(mem_store_ops), 32'(aq[0].sops));
          chk("acc_wdata", mem_wdata, aq[0].wdata);
        end else begin
          chk("acc_lops", 32'(mem_load_ops), 32'(aq[0].lops));
        end
        void'(aq.pop_front());
      end
    end
  end

  // Response-side monitor
  bit pend = 0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      pend = 0;
    end else if (rsp_valid) begin
      if (rq.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        if (!pend) begin
          pend = 1;
          chk("rsp_latency", 32'(cyc), 32'(rq[0].first));
        end
        chk("rsp_rdata", rsp_rdata, rq[0].rdata);
        chk("rsp_err", 32'(rsp_err), 32'(rq[0].err));
        chk("rsp_cause", 32'(rsp_cause), 32'(rq[0].cause));
        if (!rsp_ready) chk("rsp_hold_rdy", 32'(req_ready), 32'd0);
        if (rsp_ready) begin
          void'(rq.pop_front());
          pend = 0;
        end
      end
    end
  end

  initial begin
    lops_tab = '{3'd0, 3'd2, 3'd4, 3'd0, 3'd1, 3'd3, 3'd0, 3'd0};
    for (int i = 0; i < MB; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    req_is_store = 1'b0;
    req_funct3 = 3'd0;
    req_base = 32'd0;
    req_offset = 32'd0;
    req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mem_cs", 32'(mem_cs), 32'd1);
    chk("rst_mem_ls", 32'(mem_load_store), 32'd1);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_lops", 32'(mem_load_ops), 32'd0);
    chk("rst_sops", 32'(mem_store_ops), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_cause", 32'(rsp_cause), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;

    issue(0, 3'b010, 32'h100, 32'h4, 32'h0);
    issue(1, 3'b000, 32'h20, 32'h3, 32'h1234_56A5);
    issue(0, 3'b100, 32'h20, 32'h3, 32'h0);
    issue(0, 3'b001, 32'h100, 32'h1, 32'h0);
    issue(1, 3'b010, 32'h100, 32'h2, 32'hDEAD_BEEF);
    issue(1, 3'b010, 32'(MB - 2), 32'h0, 32'h1);
    issue(0, 3'b000, 32'hFFFF_FFFF, 32'h1, 32'h0);
    issue(0, 3'b010, 32'(MB), 32'h0, 32'h0);
    issue(1, 3'b000, 32'(MB), 32'h0, 32'h5);
    issue(0, 3'b101, 32'(MB - 2), 32'h0, 32'h0);
    issue(0, 3'b011, 32'h10, 32'h0, 32'h0);
    issue(1, 3'b101, 32'h10, 32'h0, 32'h0);
    issue(1, 3'b001, 32'h3FE, 32'hFFFF_FFFC, 32'h0000_8001);
    issue(0, 3'b001, 32'h3FA, 32'h0, 32'h0);
    drain();

    rr_mode = 1;
    issue(0, 3'b010, 32'h200, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    rr_mode = 2;
    @(posedge clk);
    #1;
    issue(0, 3'b000, 32'h200, 32'h1, 32'h0);
    rr_mode = 0;
    drain();

    req_is_store = 1'b1;
    req_funct3   = 3'b010;
    req_base     = 32'h40;
    req_offset   = 32'h0;
    req_wdata    = 32'hCAFE_F00D;
    req_valid    = 1'b1;
    rst_n        = 1'b0;
    @(negedge clk);
    chk("rst_acc_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n     = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("rst_acc_cs", 32'(mem_cs), 32'd1);
      chk("rst_acc_rv", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    issue(0, 3'b010, 32'h40, 32'h0, 32'h0);
    drain();

    for (int i = 0; i < 300; i++) begin
      bit          st;
      logic [2:0]  f3;
      logic [31:0] b, o;
      int          m;
      st = 1'($urandom_range(0, 1));
      f3 = (m = $urandom_range(0, 9)) < 8 ?
           3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      if (!st && $urandom_range(0, 2) == 0) f3 = f3 | 3'b100;
      m = $urandom_range(0, 9);
      if (m < 7) begin
        b = 32'($urandom_range(0, MB - 1));
        if (m < 5) b = b & ~32'h3;
        o = 32'($urandom_range(0, 3) * (f3[1:0] == 2'd2 ? 4 :
                                        f3[1:0] == 2'd1 ? 2 : 1));
      end else if (m < 9) begin
        b = 32'(MB - $urandom_range(1, 4));
        o = 32'($urandom_range(0, 1));
      end else begin
        b = $urandom;
        o = $urandom;
      end
      issue(st, f3, b, o, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
